// File: rtl/ls_array_sequencer_pkg.sv
// Shared types for the load/store array sequencer: precision codes, state encoding,
// the registered control bundle and the precision-to-burst-shift helper.
package ls_pkg;

    localparam int LOG_ALLOWED_PRECISIONS = 3;

    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT8  = 3'd0;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT16 = 3'd1;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT32 = 3'd2;
    localparam logic [LOG_ALLOWED_PRECISIONS-1:0] PREC_INT64 = 3'd3;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_CFG     = 4'd1;
    localparam logic [3:0] ST_LOAD_W  = 4'd2;
    localparam logic [3:0] ST_WAIT_A  = 4'd3;
    localparam logic [3:0] ST_LOAD_A  = 4'd4;
    localparam logic [3:0] ST_COMPUTE = 4'd5;
    localparam logic [3:0] ST_WAIT_O  = 4'd6;
    localparam logic [3:0] ST_STORE   = 4'd7;
    localparam logic [3:0] ST_DONE    = 4'd8;

    typedef enum logic [3:0] {
        S_IDLE    = ST_IDLE,
        S_CFG     = ST_CFG,
        S_LOAD_W  = ST_LOAD_W,
        S_WAIT_A  = ST_WAIT_A,
        S_LOAD_A  = ST_LOAD_A,
        S_COMPUTE = ST_COMPUTE,
        S_WAIT_O  = ST_WAIT_O,
        S_STORE   = ST_STORE,
        S_DONE    = ST_DONE
    } state_t;

    typedef struct packed {
        logic busy;
        logic done;
        logic err;
        logic infifo_read;
        logic outfifo_write;
        logic read_weight_memory;
        logic enable_load_activation_data;
        logic enable_store_activation_data;
        logic enable_cnt;
        logic ld_max_cnt;
        logic enable_down_cnt;
        logic ld_max_down_cnt;
        logic enable_cnt_weight;
        logic ld_max_cnt_weight;
    } ctrl_t;

    function automatic logic prec_valid(input logic [LOG_ALLOWED_PRECISIONS-1:0] code);
        return code <= PREC_INT64;
    endfunction

    // log2(DATA_W / p) with p = 8 << code; clamps to 0 when p is not narrower than a word
    function automatic int unsigned prec_shift(input logic [LOG_ALLOWED_PRECISIONS-1:0] code,
                                               input int unsigned data_w_log2);
        int unsigned p_log2;
        p_log2 = 32'd3 + 32'(code);
        if (data_w_log2 > p_log2)
            return data_w_log2 - p_log2;
        return 0;
    endfunction

endpackage

// File: rtl/ls_array_sequencer_beat_counter.sv
// Down-counting beat timer shared by all timed sequencer states; tc flags the last beat.
module beat_counter #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] load_value,
    output logic         tc
);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (!reset_n)
            count <= '0;
        else if (load)
            count <= load_value;
        else if (enable && count != '0)
            count <= count - W'(1);
    end

    assign tc = (count == '0);

endmodule

// File: rtl/ls_array_sequencer.sv
// Tile sequencer for the load/store array: weight fetch, activation load, compute wait, drain.
//   state   | meaning
//   IDLE    | waiting for start, precision latched on accept
//   CFG     | load max_* counts into the array counters
//   LOAD_W  | weight memory burst, beats_w cycles
//   WAIT_A  | wait for infifo_level >= beats_a
//   LOAD_A  | activation burst from input FIFO, beats_a cycles
//   COMPUTE | MXU_LATENCY cycles
//   WAIT_O  | wait for outfifo_space >= beats_o
//   STORE   | result burst to output FIFO, beats_o cycles
//   DONE    | done pulse (err too if precision invalid)
module ls_array_sequencer
    import ls_pkg::*;
#(
    parameter int ROWS        = 4,
    parameter int COLUMNS     = 4,
    parameter int DATA_W      = 64,
    parameter int MXU_LATENCY = 8,
    parameter int LVL_W       = 6
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                start,
    input  logic [LOG_ALLOWED_PRECISIONS-1:0]   precision,
    output logic                                busy,
    output logic                                done,
    output logic                                err,
    input  logic [LVL_W-1:0]                    infifo_level,
    input  logic [LVL_W-1:0]                    outfifo_space,
    output logic [LOG_ALLOWED_PRECISIONS-1:0]   data_precision,
    output logic                                enable_load_array,
    output logic                                infifo_read,
    output logic                                outfifo_write,
    output logic                                read_weight_memory,
    output logic                                enable_load_activation_data,
    output logic                                enable_store_activation_data,
    output logic                                enable_cnt,
    output logic                                ld_max_cnt,
    output logic                                enable_down_cnt,
    output logic                                ld_max_down_cnt,
    output logic                                enable_cnt_weight,
    output logic                                ld_max_cnt_weight,
    output logic [$clog2(COLUMNS):0]            max_cnt_from_cu,
    output logic [$clog2(ROWS):0]               max_down_cnt_from_cu,
    output logic [$clog2(ROWS):0]               max_cnt_weight_from_cu
);

    localparam int CW      = $clog2(COLUMNS) + 1;
    localparam int RW      = $clog2(ROWS) + 1;
    localparam int DW_LOG2 = $clog2(DATA_W);
    localparam int CNT_W   = 6;

    state_t                              state, state_nxt;
    ctrl_t                               ctrl_q, ctrl_nxt;
    logic [LOG_ALLOWED_PRECISIONS-1:0]   prec_q;
    logic [CW-1:0]                       beats_a_q, beats_a_in;
    logic [RW-1:0]                       beats_w_q, beats_w_in;
    int unsigned                         shift_in;
    logic                                prec_ok, infifo_ok, outfifo_ok;
    logic                                cnt_load, cnt_en, cnt_tc;
    logic [CNT_W-1:0]                    cnt_load_val;

    // Burst lengths for the incoming precision, captured on the accepting edge
    always_comb begin
        shift_in   = prec_shift(precision, DW_LOG2);
        beats_a_in = CW'(COLUMNS >> shift_in);
        beats_w_in = RW'(ROWS >> shift_in);
        if (beats_a_in == '0)
            beats_a_in = CW'(1);
        if (beats_w_in == '0)
            beats_w_in = RW'(1);
    end

    assign prec_ok    = prec_valid(prec_q);
    assign infifo_ok  = infifo_level >= LVL_W'(beats_a_q);
    assign outfifo_ok = outfifo_space >= LVL_W'(beats_w_q);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start) state_nxt = S_CFG;
            S_CFG:     state_nxt = prec_ok ? S_LOAD_W : S_DONE;
            S_LOAD_W:  if (cnt_tc) state_nxt = infifo_ok ? S_LOAD_A : S_WAIT_A;
            S_WAIT_A:  if (infifo_ok) state_nxt = S_LOAD_A;
            S_LOAD_A:  if (cnt_tc) state_nxt = S_COMPUTE;
            S_COMPUTE: if (cnt_tc) state_nxt = outfifo_ok ? S_STORE : S_WAIT_O;
            S_WAIT_O:  if (outfifo_ok) state_nxt = S_STORE;
            S_STORE:   if (cnt_tc) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Counter reloads on every state entry, so each timed state starts a fresh count
    always_comb begin
        cnt_load     = (state_nxt != state);
        cnt_en       = (state == S_LOAD_W) || (state == S_LOAD_A) ||
                       (state == S_COMPUTE) || (state == S_STORE);
        cnt_load_val = '0;
        case (state_nxt)
            S_LOAD_W:  cnt_load_val = CNT_W'(beats_w_q) - CNT_W'(1);
            S_LOAD_A:  cnt_load_val = CNT_W'(beats_a_q) - CNT_W'(1);
            S_COMPUTE: cnt_load_val = CNT_W'(MXU_LATENCY - 1);
            S_STORE:   cnt_load_val = CNT_W'(beats_w_q) - CNT_W'(1);
            default:   cnt_load_val = '0;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they align with state
    always_comb begin
        ctrl_nxt      = '0;
        ctrl_nxt.busy = (state_nxt != S_IDLE);
        case (state_nxt)
            S_CFG: begin
                ctrl_nxt.ld_max_cnt        = 1'b1;
                ctrl_nxt.ld_max_down_cnt   = 1'b1;
                ctrl_nxt.ld_max_cnt_weight = 1'b1;
            end
            S_LOAD_W: begin
                ctrl_nxt.read_weight_memory = 1'b1;
                ctrl_nxt.enable_cnt_weight  = 1'b1;
            end
            S_LOAD_A: begin
                ctrl_nxt.infifo_read                 = 1'b1;
                ctrl_nxt.enable_cnt                  = 1'b1;
                ctrl_nxt.enable_load_activation_data = 1'b1;
            end
            S_STORE: begin
                ctrl_nxt.enable_store_activation_data = 1'b1;
                ctrl_nxt.enable_down_cnt              = 1'b1;
                ctrl_nxt.outfifo_write                = 1'b1;
            end
            S_DONE: begin
                ctrl_nxt.done = 1'b1;
                ctrl_nxt.err  = !prec_ok;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            ctrl_q    <= '0;
            prec_q    <= '0;
            beats_a_q <= '0;
            beats_w_q <= '0;
        end else begin
            state  <= state_nxt;
            ctrl_q <= ctrl_nxt;
            if (state == S_IDLE && start) begin
                prec_q    <= precision;
                beats_a_q <= beats_a_in;
                beats_w_q <= beats_w_in;
            end
        end
    end

    beat_counter #(.W(CNT_W)) u_beat_counter (
        .clk        (clk),
        .reset_n    (reset_n),
        .load       (cnt_load),
        .enable     (cnt_en),
        .load_value (cnt_load_val),
        .tc         (cnt_tc)
    );

    assign busy                         = ctrl_q.busy;
    assign enable_load_array            = ctrl_q.busy;
    assign done                         = ctrl_q.done;
    assign err                          = ctrl_q.err;
    assign infifo_read                  = ctrl_q.infifo_read;
    assign outfifo_write                = ctrl_q.outfifo_write;
    assign read_weight_memory           = ctrl_q.read_weight_memory;
    assign enable_load_activation_data  = ctrl_q.enable_load_activation_data;
    assign enable_store_activation_data = ctrl_q.enable_store_activation_data;
    assign enable_cnt                   = ctrl_q.enable_cnt;
    assign ld_max_cnt                   = ctrl_q.ld_max_cnt;
    assign enable_down_cnt              = ctrl_q.enable_down_cnt;
    assign ld_max_down_cnt              = ctrl_q.ld_max_down_cnt;
    assign enable_cnt_weight            = ctrl_q.enable_cnt_weight;
    assign ld_max_cnt_weight            = ctrl_q.ld_max_cnt_weight;
    assign data_precision               = prec_q;
    assign max_cnt_from_cu              = beats_a_q;
    assign max_down_cnt_from_cu         = beats_w_q;
    assign max_cnt_weight_from_cu       = beats_w_q;

endmodule

// File: tb/tb_ls_array_sequencer.sv
// Bench for ls_array_sequencer: table of tile requests, expected results queued on start
// and compared when done pulses, plus a mid-tile reset sequence.
module tb_ls_array_sequencer;

    localparam int ROWS    = 4;
    localparam int COLUMNS = 4;
    localparam int DATA_W  = 64;
    localparam int MXU_LAT = 8;
    localparam int LVL_W   = 6;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [2:0]       precision;
    logic             busy, done, err;
    logic [LVL_W-1:0] infifo_level, outfifo_space;
    logic [2:0]       data_precision;
    logic             enable_load_array, infifo_read, outfifo_write, read_weight_memory;
    logic             enable_load_activation_data, enable_store_activation_data;
    logic             enable_cnt, ld_max_cnt, enable_down_cnt, ld_max_down_cnt;
    logic             enable_cnt_weight, ld_max_cnt_weight;
    logic [2:0]       max_cnt_from_cu, max_down_cnt_from_cu, max_cnt_weight_from_cu;

    ls_array_sequencer #(
        .ROWS(ROWS), .COLUMNS(COLUMNS), .DATA_W(DATA_W), .MXU_LATENCY(MXU_LAT), .LVL_W(LVL_W)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .precision(precision),
        .busy(busy), .done(done), .err(err),
        .infifo_level(infifo_level), .outfifo_space(outfifo_space),
        .data_precision(data_precision), .enable_load_array(enable_load_array),
        .infifo_read(infifo_read), .outfifo_write(outfifo_write),
        .read_weight_memory(read_weight_memory),
        .enable_load_activation_data(enable_load_activation_data),
        .enable_store_activation_data(enable_store_activation_data),
        .enable_cnt(enable_cnt), .ld_max_cnt(ld_max_cnt),
        .enable_down_cnt(enable_down_cnt), .ld_max_down_cnt(ld_max_down_cnt),
        .enable_cnt_weight(enable_cnt_weight), .ld_max_cnt_weight(ld_max_cnt_weight),
        .max_cnt_from_cu(max_cnt_from_cu), .max_down_cnt_from_cu(max_down_cnt_from_cu),
        .max_cnt_weight_from_cu(max_cnt_weight_from_cu)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] prec;
        int         in_lvl;
        int         in_raise;   // cycle at which infifo_level jumps to 32 (0 = never)
        int         out_spc;
        int         out_raise;
        int         mid_start;  // cycle at which a stray start is pulsed (0 = never)
    } vec_t;

    typedef struct {
        int         err;
        int         lat;        // -1 when the tile stalls and latency is not checked
        int         ba;
        int         bw;
        int         bo;
        logic [2:0] prec;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    logic [26:0] all_outs;

    assign all_outs = {busy, done, err, enable_load_array, infifo_read, outfifo_write,
                       read_weight_memory, enable_load_activation_data,
                       enable_store_activation_data, enable_cnt, ld_max_cnt, enable_down_cnt,
                       ld_max_down_cnt, enable_cnt_weight, ld_max_cnt_weight,
                       max_cnt_from_cu, max_down_cnt_from_cu, max_cnt_weight_from_cu,
                       data_precision};

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, want);
        end
    endtask

    // Reference model: beats = max(1, N*p/DATA_W); done appears tile_len-1 cycles after
    // the start edge, where tile_len counts the start cycle itself.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        int   bits;
        bits   = 8 << v.prec;
        e.prec = v.prec;
        if (v.prec > 3) begin
            e.err = 1; e.lat = 2; e.ba = 0; e.bw = 0; e.bo = 0;
        end else begin
            e.err = 0;
            e.ba  = (COLUMNS * bits) / DATA_W; if (e.ba == 0) e.ba = 1;
            e.bw  = (ROWS * bits) / DATA_W;    if (e.bw == 0) e.bw = 1;
            e.bo  = e.bw;
            if (v.in_lvl >= e.ba && v.out_spc >= e.bo)
                e.lat = 1 + 1 + e.bw + e.ba + MXU_LAT + e.bo + 1 - 1;
            else
                e.lat = -1;
        end
        return e;
    endfunction

    task automatic run_tile(input vec_t v);
        exp_t e, g;
        int cyc, lvl, spc, lat, gap, early_rd, early_wr;
        int n_rd, f_rd, l_rd, n_wr, f_wr, l_wr, n_rwm, f_rwm, l_rwm;
        int err_at, prec_at;
        bit seen;
        e = model(v);
        @(negedge clk);
        lvl = v.in_lvl; spc = v.out_spc;
        infifo_level = lvl[LVL_W-1:0]; outfifo_space = spc[LVL_W-1:0];
        precision = v.prec; start = 1'b1;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; precision = v.prec ^ 3'b101;
        cyc = 1; seen = 0; lat = 0; gap = 0; early_rd = 0; early_wr = 0; err_at = 0; prec_at = 0;
        n_rd = 0; f_rd = -1; l_rd = -2; n_wr = 0; f_wr = -1; l_wr = -2;
        n_rwm = 0; f_rwm = -1; l_rwm = -2;
        while (cyc <= 300 && !seen) begin
            if (cyc == 1) begin
                check("cfg_ld_max", int'({ld_max_cnt, ld_max_down_cnt, ld_max_cnt_weight}), 7);
                if (e.err == 0) begin
                    check("max_cnt_from_cu", int'(max_cnt_from_cu), e.ba);
                    check("max_cnt_weight", int'(max_cnt_weight_from_cu), e.bw);
                end
            end
            if (!busy && !done) gap++;
            if (infifo_read) begin
                n_rd++; if (f_rd < 0) f_rd = cyc; l_rd = cyc;
                if (lvl < e.ba) early_rd++;
            end
            if (outfifo_write) begin
                n_wr++; if (f_wr < 0) f_wr = cyc; l_wr = cyc;
                if (spc < e.bo) early_wr++;
            end
            if (read_weight_memory) begin
                n_rwm++; if (f_rwm < 0) f_rwm = cyc; l_rwm = cyc;
            end
            if (done) begin
                seen = 1; lat = cyc; err_at = int'(err); prec_at = int'(data_precision);
            end else begin
                if (v.in_raise == cyc) lvl = 32;
                if (v.out_raise == cyc) spc = 32;
                if (v.mid_start == cyc) begin start = 1'b1; precision = 3'd0; end
                else start = 1'b0;
                infifo_level = lvl[LVL_W-1:0]; outfifo_space = spc[LVL_W-1:0];
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            checks++; failures++;
            $display("FAIL done_timeout got=no_done expected=done prec=%0d", v.prec);
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            return;
        end
        g = exp_q.pop_front();
        if (g.lat >= 0) check("done_latency", lat, g.lat);
        check("err_with_done", err_at, g.err);
        check("data_precision", prec_at, int'(g.prec));
        check("weight_beats", n_rwm, g.bw);
        check("weight_contig", l_rwm - f_rwm + 1, n_rwm);
        check("infifo_reads", n_rd, g.ba);
        check("infifo_contig", l_rd - f_rd + 1, n_rd);
        check("outfifo_writes", n_wr, g.bo);
        check("outfifo_contig", l_wr - f_wr + 1, n_wr);
        check("read_before_level", early_rd, 0);
        check("write_before_space", early_wr, 0);
        check("busy_done_gap", gap, 0);
        @(negedge clk);
        check("idle_after_done", int'({busy, done}), 0);
    endtask

    vec_t vecs[10];

    initial begin
        int bad_done;
        vecs[0] = '{3'd3, 63, 0, 63, 0, 0};
        vecs[1] = '{3'd1, 63, 0, 63, 0, 0};
        vecs[2] = '{3'd0, 63, 0, 63, 0, 0};
        vecs[3] = '{3'd2, 63, 0, 63, 0, 8};
        vecs[4] = '{3'd4, 63, 0, 63, 0, 0};
        vecs[5] = '{3'd7, 0, 0, 0, 0, 0};
        vecs[6] = '{3'd3, 2, 20, 63, 0, 0};
        vecs[7] = '{3'd3, 63, 0, 0, 25, 0};
        vecs[8] = '{3'd2, 1, 12, 1, 30, 0};
        vecs[9] = '{3'd3, 4, 0, 4, 0, 0};

        reset_n = 1'b0; start = 1'b0; precision = 3'd3;
        infifo_level = '0; outfifo_space = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_all_outputs", int'(all_outs), 0);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("start_in_reset_ignored", int'(busy), 0);
        start = 1'b0;
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) run_tile(vecs[i]);

        // Reset during LOAD_A aborts without a done pulse
        @(negedge clk);
        precision = 3'd3; start = 1'b1; infifo_level = 6'd63; outfifo_space = 6'd63;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("in_load_a_before_reset", int'(infifo_read), 1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("outputs_after_reset", int'(all_outs), 0);
        bad_done = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done || busy) bad_done++;
        end
        check("no_done_after_abort", bad_done, 0);
        run_tile(vecs[0]);

        check("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
